// File: rtl/watch_pkg.sv
// watch_pkg: shared types and constants for the watch_core clock block.
// Holds the FSM state encoding, active-low seven-segment digit codes
// (bit0=a .. bit6=g, bit7=dp, dp always off) and a BCD increment helper.
package watch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Display image for 00:00:00, byte 0 in bits 7:0.
    localparam logic [63:0] SEG_RESET = 64'hC0C0BFC0C0BFC0C0;

    // Two-digit BCD increment that wraps to 00 once max_v is reached.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: combinational BCD digit to active-low segment pattern.
// Codes outside 0-9 render blank.
module seg7_encode
    import watch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    // Look up the segment pattern for one BCD digit.
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/watch_core.sv
// watch_core: 24-hour BCD clock with RUN / SET_H / SET_M modes and a
// registered eight-digit segment image (HH-MM-SS) plus change pulse.
// Optional macro WATCH_CORE_BLINK_EN blinks the field being set.
module watch_core
    import watch_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [63:0] seg_word,
    output logic        seg_valid,
    output logic [1:0]  mode
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_q;
    logic          mode_prev_q, inc_prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic [63:0]   seg_q, seg_d;
    logic          seg_valid_q;
    logic          mode_press_s, inc_press_s, tick_s;
    logic          blank_h_s, blank_m_s;
    logic [7:0]    hr_t_s, hr_u_s, min_t_s, min_u_s, sec_t_s, sec_u_s;

    // A mode press in the same cycle swallows any increment press.
    assign mode_press_s = btn_mode & ~mode_prev_q;
    assign inc_press_s  = btn_inc & ~inc_prev_q & ~mode_press_s;
    assign tick_s       = (presc_q == PRESC_LAST);

    // Mode FSM: each mode press advances RUN -> SET_H -> SET_M -> RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else if (mode_press_s) begin
            case (state_q)
                ST_RUN:   state_q <= ST_SET_H;
                ST_SET_H: state_q <= ST_SET_M;
                ST_SET_M: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    // Next time/prescaler: ticks only count in RUN, set states edit one field.
    always_comb begin
        presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        case (state_q)
            ST_RUN: begin
                if (tick_s) begin
                    sec_d = bcd_inc_wrap(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc_wrap(min_q, 8'h59);
                        if (min_q == 8'h59) begin
                            hr_d = bcd_inc_wrap(hr_q, 8'h23);
                        end else begin
                            hr_d = hr_q;
                        end
                    end else begin
                        min_d = min_q;
                    end
                end else begin
                    sec_d = sec_q;
                end
            end
            ST_SET_H: begin
                if (inc_press_s) begin
                    hr_d = bcd_inc_wrap(hr_q, 8'h23);
                end else begin
                    hr_d = hr_q;
                end
            end
            ST_SET_M: begin
                // Leaving SET_M restarts the running second from zero.
                if (mode_press_s) begin
                    sec_d   = 8'h00;
                    presc_d = {PW{1'b0}};
                end else if (inc_press_s) begin
                    min_d = bcd_inc_wrap(min_q, 8'h59);
                end else begin
                    min_d = min_q;
                end
            end
            default: begin
                hr_d  = hr_q;
                min_d = min_q;
                sec_d = sec_q;
            end
        endcase
    end

    // Time, prescaler and button edge registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= {PW{1'b0}};
            hr_q        <= 8'h00;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
        end
    end

`ifdef WATCH_CORE_BLINK_EN
    localparam int            HALF      = (TICK_DIV / 2 > 1) ? TICK_DIV / 2 : 1;
    localparam int            BW        = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

    logic [BW-1:0] blink_cnt_q;
    logic          blink_ph_q;
    logic          enter_set_s;

    assign enter_set_s = mode_press_s & (state_q != ST_SET_M);

    // Blink phase toggles every TICK_DIV/2 cycles, restarting on entry to a set state.
    always_ff @(posedge clk) begin
        if (reset || enter_set_s) begin
            blink_cnt_q <= {BW{1'b0}};
            blink_ph_q  <= 1'b0;
        end else if (blink_cnt_q == HALF_LAST) begin
            blink_cnt_q <= {BW{1'b0}};
            blink_ph_q  <= ~blink_ph_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
            blink_ph_q  <= blink_ph_q;
        end
    end

    assign blank_h_s = blink_ph_q & (state_q == ST_SET_H);
    assign blank_m_s = blink_ph_q & (state_q == ST_SET_M);
`else
    assign blank_h_s = 1'b0;
    assign blank_m_s = 1'b0;
`endif

    seg7_encode u_hr_t  (.bcd_i(hr_q[7:4]),  .seg_o(hr_t_s));
    seg7_encode u_hr_u  (.bcd_i(hr_q[3:0]),  .seg_o(hr_u_s));
    seg7_encode u_min_t (.bcd_i(min_q[7:4]), .seg_o(min_t_s));
    seg7_encode u_min_u (.bcd_i(min_q[3:0]), .seg_o(min_u_s));
    seg7_encode u_sec_t (.bcd_i(sec_q[7:4]), .seg_o(sec_t_s));
    seg7_encode u_sec_u (.bcd_i(sec_q[3:0]), .seg_o(sec_u_s));

    // Assemble the display image; byte 0 is the leftmost digit.
    always_comb begin
        seg_d = {sec_u_s, sec_t_s, SEG_DASH,
                 blank_m_s ? SEG_BLANK : min_u_s,
                 blank_m_s ? SEG_BLANK : min_t_s,
                 SEG_DASH,
                 blank_h_s ? SEG_BLANK : hr_u_s,
                 blank_h_s ? SEG_BLANK : hr_t_s};
    end

    // Register the image and flag cycles where it changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= SEG_RESET;
            seg_valid_q <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            seg_valid_q <= (seg_d != seg_q);
        end
    end

    assign seg_word  = seg_q;
    assign seg_valid = seg_valid_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_watch_core.sv
// tb_watch_core: directed plus random stimulus against a behavioural
// clock model (plain h/m/s integer arithmetic) with immediate assertions.
module tb_watch_core;

    localparam int TD = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        btn_mode  = 1'b0;
    logic        btn_inc   = 1'b0;
    logic [63:0] seg_word;
    logic        seg_valid;
    logic [1:0]  mode;

    watch_core #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .seg_word  (seg_word),
        .seg_valid (seg_valid),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int vcnt   = 0;

    // Reference model state
    int          mh, mm, ms, mst, mpres, mk;
    logic        pm, pi;
    logic [63:0] exp_seg, pend_seg;
    logic        exp_valid;

    logic [7:0] dig [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [63:0] img(input int h, input int m, input int s,
                                        input int st, input int k);
        logic [63:0] w;
        logic bh, bm;
        bh = 1'b0;
        bm = 1'b0;
`ifdef WATCH_CORE_BLINK_EN
        if (((k / ((TD / 2 > 1) ? TD / 2 : 1)) % 2) == 1) begin
            bh = (st == 1);
            bm = (st == 2);
        end
`endif
        w[7:0]   = bh ? 8'hFF : dig[h / 10];
        w[15:8]  = bh ? 8'hFF : dig[h % 10];
        w[23:16] = 8'hBF;
        w[31:24] = bm ? 8'hFF : dig[m / 10];
        w[39:32] = bm ? 8'hFF : dig[m % 10];
        w[47:40] = 8'hBF;
        w[55:48] = dig[s / 10];
        w[63:56] = dig[s % 10];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance model, compare all outputs.
    task automatic cyc(input logic bm, input logic bi, input logic rs);
        logic mp, ip, tick;
        int t;
        @(negedge clk);
        btn_mode = bm;
        btn_inc  = bi;
        reset    = rs;
        @(posedge clk);
        if (rs) begin
            mh = 0; mm = 0; ms = 0; mst = 0; mpres = 0; mk = 0;
            pm = 1'b0; pi = 1'b0;
            exp_seg   = 64'hC0C0BFC0C0BFC0C0;
            pend_seg  = img(0, 0, 0, 0, 0);
            exp_valid = 1'b0;
        end else begin
            exp_valid = (pend_seg !== exp_seg);
            exp_seg   = pend_seg;
            mp = bm && !pm;
            ip = bi && !pi && !mp;
            pm = bm;
            pi = bi;
            tick  = (mpres == TD - 1);
            mpres = (mpres + 1) % TD;
            if (mst == 0 && tick) begin
                t  = (mh * 3600 + mm * 60 + ms + 1) % 86400;
                mh = t / 3600;
                mm = (t / 60) % 60;
                ms = t % 60;
            end
            if (mst == 1 && ip) mh = (mh + 1) % 24;
            if (mst == 2 && ip) mm = (mm + 1) % 60;
            if (mp) begin
                if (mst == 2) begin
                    ms    = 0;
                    mpres = 0;
                end
                mst = (mst + 1) % 3;
                mk  = 0;
            end else begin
                mk++;
            end
            pend_seg = img(mh, mm, ms, mst, mk);
        end
        #1;
        chk("mode", 64'(mode), 64'(mst));
        chk("seg_word", seg_word, exp_seg);
        chk("seg_valid", 64'(seg_valid), 64'(exp_valid));
        if (seg_valid === 1'b1) vcnt++;
    endtask

    task automatic press_mode();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst_seg", seg_word, 64'hC0C0BFC0C0BFC0C0);
        chk("rst_valid", 64'(seg_valid), 64'd0);

        // Free run: three ticks in twelve cycles, image follows one cycle later
        vcnt = 0;
        repeat (13) cyc(1'b0, 1'b0, 1'b0);
        chk("run_sec_t", 64'(seg_word[55:48]), 64'h00C0);
        chk("run_sec_u", 64'(seg_word[63:56]), 64'h00B0);
        chk("run_pulses", 64'(vcnt), 64'd3);

        // SET_H: held increment counts once, ticks ignored
        press_mode();
        chk("seth_mode", 64'(mode), 64'd1);
        repeat (10) cyc(1'b0, 1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        chk("seth_hr_t", 64'(seg_word[7:0]), 64'h00C0);
        chk("seth_hr_u", 64'(seg_word[15:8]), 64'h00F9);
        chk("seth_sec_u", 64'(seg_word[63:56]), 64'h00B0);

        // Simultaneous mode and inc: mode wins
        cyc(1'b1, 1'b1, 1'b0);
        chk("same_mode", 64'(mode), 64'd2);
        cyc(1'b0, 1'b0, 1'b0);
        chk("same_hr_u", 64'(seg_word[15:8]), 64'h00F9);

        // Preload 23:59 then run across midnight
        press_inc(59);
        press_mode();
        press_mode();
        press_inc(22);
        press_mode();
        press_mode();
        chk("pre_mode", 64'(mode), 64'd0);
        for (int n = 0; n < 400 && !(mh == 23 && mm == 59 && ms == 59); n++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("seg_235959", seg_word, 64'h9092BF9092BFB0A4);
        for (int n = 0; n < 8 && !(mh == 0 && mm == 0 && ms == 0); n++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("midnight_seg", seg_word, 64'hC0C0BFC0C0BFC0C0);
        chk("midnight_valid", 64'(seg_valid), 64'd1);

        // Random button activity against the model
        repeat (400) cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0), 1'b0);

        // Reset in SET_M at 07:42
        cyc(1'b0, 1'b0, 1'b1);
        press_mode();
        press_inc(7);
        press_mode();
        press_inc(42);
        chk("s0742_mode", 64'(mode), 64'd2);
        repeat (8) begin
            cyc(1'b0, 1'b0, 1'b0);
`ifndef WATCH_CORE_BLINK_EN
            chk("noblink_b3", 64'(seg_word[31:24] == 8'hFF), 64'd0);
            chk("noblink_b4", 64'(seg_word[39:32] == 8'hFF), 64'd0);
`endif
        end
        chk("s0742_hr_u", 64'(seg_word[15:8]), 64'h00F8);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst_setm_mode", 64'(mode), 64'd0);
        chk("rst_setm_seg", seg_word, 64'hC0C0BFC0C0BFC0C0);
        chk("rst_setm_valid", 64'(seg_valid), 64'd0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
